id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Parametrised ID->EX pipeline stage register with a valid/ready handshake, stall back-pressure, flush-to-bubble and an optional 2-entry skid buffer.
- Replaces hand-written, fixed-field, always-advancing stage registers.
- Operand/immediate/PC/instruction words are carried as a packed data bus; decoded control bits are carried as a packed control bus.
- Sits between decode and execute; the hazard unit drives flush and out_ready.

Parameters:
DATA_W, 32, width of one data word
NUM_DATA, 5, number of data words carried (rs value, rt value, sign-extended imm, PC+4, instruction)
CTRL_W, 14, width of packed control vector (RegDst, BranchEQ/NE, MemRead, MemToReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, Jump, trunkMode[1:0], ShiftToTrunk)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage accepts in_data/in_ctrl this cycle
in_data  in  NUM_DATA*DATA_W  packed data words, word 0 in LSBs
in_ctrl  in  CTRL_W  packed control vector
flush  in  1  kill all held entries (branch/jump taken, load-use bubble)
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute accepts entry (0 = stall)
out_data  out  NUM_DATA*DATA_W  held data words
out_ctrl  out  CTRL_W  held control vector; forced to 0 whenever out_valid=0
count  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Accept = in_valid & in_ready. Issue = out_valid & out_ready.
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ctrl=0, count=0, skid entry cleared, in_ready=1 from the next cycle. Reset overrides flush and all handshakes, including mid-stall.
- Flush (rst=0, flush=1): at the edge, both entries are invalidated, count=0, out_ctrl=0, out_valid=0. An Accept in the same cycle is discarded. in_ready=1 in the next cycle. out_data may keep stale values.
- Bubble guarantee: out_ctrl is all-zero whenever out_valid=0. No RegWrite/MemWrite/Branch/Jump is ever visible on a bubble.
- Hold: while out_valid=1 and out_ready=0, out_data and out_ctrl are bit-stable.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On Accept the main register loads and out_valid=1.
  - On Issue without Accept, out_valid=0.
  - Latency is 1 cycle.
  - Full throughput when out_ready=1.
- SKID=1, state = count:
  - EMPTY(0): Accept -> main loads, count=1.
  - ONE(1):
    - Accept & Issue -> main reloads, stays ONE.
    - Issue only -> EMPTY.
    - Accept only -> skid loads, FULL.
  - FULL(2):
    - in_ready=0, so no Accept is possible.
    - Issue -> skid moves to main, ONE.
  - in_ready is registered and equals (next count < 2).
  - An in_valid asserted in the cycle out_ready drops is still captured (skid).
  - Latency is 1 cycle. Order is strictly FIFO. Full throughput when out_ready=1.
- Accept with in_valid=1 but in_ready=0: no state change. Upstream must hold its data.
- count and out_valid update in the same edge. out_valid = (count != 0).
- No combinational path from in_data/in_ctrl to out_*. With SKID=1 there is also none from out_ready to in_ready.

Test Plan:
- Reset: drive in_valid=1, in_ctrl=14'h3FFF during rst=1 for 3 cycles -> out_valid=0, out_ctrl=0, count=0. After release in_ready=1 and the first Accept appears at out_* one cycle later.
- Streaming: out_ready=1, 8 back-to-back words with data word0 = 0x1000+i -> out_data word0 = 0x1000..0x1007 on consecutive cycles, 1-cycle latency, no gaps.
- Stall/skid (SKID=1): send A(0xA), B(0xB), drop out_ready after A arrives, hold 4 cycles -> out_data=0xA stable, count=2, in_ready=0. Raise out_ready -> A, then B, then count=0. C offered during the stall is taken only after in_ready returns to 1.
- Flush while FULL: count=2 with ctrl=14'h0204, flush=1 plus simultaneous Accept of D -> next cycle out_valid=0, out_ctrl=0, count=0, D never appears, in_ready=1.
- SKID=0 variant: out_ready=0 with held entry -> in_ready=0 the same cycle. Raise out_ready with in_valid=1 -> Issue and Accept on one edge, next entry visible, count stays 1.
- Parameter sweep: DATA_W=16, NUM_DATA=2, CTRL_W=4 -> packing is correct (word1 in bits [31:16]), and all scenarios above pass.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX stage register with valid/ready handshake, flush-to-bubble and an
// optional 2-entry skid buffer (SKID=1) that keeps in_ready off the out_ready path.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 5,
  parameter int CTRL_W   = 14,
  parameter int SKID     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [1:0]                   count
);

  localparam int DW = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic                rdy_q;
  logic                accept, issue;

  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;
  assign out_data  = main_data_q;
  // Bubbles must never carry live control bits downstream.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign in_ready  = (SKID != 0) ? rdy_q : (out_ready | ~out_valid);

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = ONE;
        end
        ONE: begin
          if (accept && issue) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (issue) begin
            state_d = EMPTY;
          end else if (accept && SKID != 0) begin
            // Late out_ready drop: park the new entry behind the held one.
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end
        end
        FULL: if (issue) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_q       <= (state_d != FULL);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three instances (skid, no-skid, narrow skid) share one
// stimulus stream and are checked every cycle against FIFO-queue models.
module tb_id_ex_stage;

  typedef struct packed {
    logic [159:0] d;
    logic [13:0]  c;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [159:0] in_data = '0;
  logic [13:0]  in_ctrl = '0;
  logic [31:0]  ds_in_data;

  logic         o_valid [3];
  logic         o_ready [3];
  logic [1:0]   o_cnt   [3];
  logic [159:0] o_data  [3];
  logic [13:0]  o_ctrl  [3];
  logic [31:0]  ds_out_data;
  logic [3:0]   ds_out_ctrl;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  armed   = 1'b0;
  ent_t mq [3][$];

  always #5 clk = ~clk;

  // Narrow instance: word0 = low half of wide word0, word1 = low half of wide word1.
  assign ds_in_data = {in_data[47:32], in_data[15:0]};
  assign o_data[2]  = {128'b0, ds_out_data};
  assign o_ctrl[2]  = {10'b0, ds_out_ctrl};

  id_ex_stage #(.SKID(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]),
    .out_ctrl(o_ctrl[0]), .count(o_cnt[0]));

  id_ex_stage #(.SKID(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]),
    .out_ctrl(o_ctrl[1]), .count(o_cnt[1]));

  id_ex_stage #(.DATA_W(16), .NUM_DATA(2), .CTRL_W(4), .SKID(1)) ds (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[2]),
    .in_data(ds_in_data), .in_ctrl(in_ctrl[3:0]), .flush(flush),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_data(ds_out_data),
    .out_ctrl(ds_out_ctrl), .count(o_cnt[2]));

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input int k);
    ent_t e;
    if (k == 2) begin
      e.d = {128'b0, ds_in_data};
      e.c = {10'b0, in_ctrl[3:0]};
    end else begin
      e.d = in_data;
      e.c = in_ctrl;
    end
    return e;
  endfunction

  // Instance 1 has no skid: capacity 1, ready whenever the slot frees this cycle.
  function automatic bit m_rdy(input int k);
    int sz;
    sz = mq[k].size();
    if (k == 1) return out_ready || sz == 0;
    return sz < 2;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit iss, acc;
      iss = mq[k].size() > 0 && out_ready;
      acc = in_valid && m_rdy(k);
      if (rst || flush) mq[k].delete();
      else begin
        if (iss) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(mk(k));
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        int sz;
        sz = mq[k].size();
        chk($sformatf("d%0d out_valid", k), o_valid[k], sz > 0);
        chk($sformatf("d%0d count", k), o_cnt[k], sz);
        chk($sformatf("d%0d in_ready", k), o_ready[k], m_rdy(k));
        chk($sformatf("d%0d out_ctrl", k), o_ctrl[k], sz > 0 ? mq[k][0].c : 14'h0);
        if (sz > 0) chk($sformatf("d%0d out_data", k), o_data[k], mq[k][0].d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [13:0] c);
    in_valid = v;
    in_data  = {$urandom, $urandom, $urandom, w1, w0};
    in_ctrl  = c;
  endtask

  initial begin
    // Reset with a live-looking input pending.
    rst = 1'b1;
    set_in(1'b1, 32'h55, 32'h66, 14'h3FFF);
    repeat (3) begin
      step();
      chk("rst out_valid", o_valid[0], 1'b0);
      chk("rst out_ctrl", o_ctrl[0], 14'h0);
      chk("rst count", o_cnt[0], 2'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-rst in_ready skid", o_ready[0], 1'b1);
    chk("post-rst in_ready noskid", o_ready[1], 1'b1);

    // Streaming, 1-cycle latency, no gaps.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'h1000 + i, 32'h2000 + i, 14'($urandom));
      step();
      chk("stream d1 word0", o_data[0][31:0], 32'h1000 + i);
      chk("stream d0 word0", o_data[1][31:0], 32'h1000 + i);
      chk("stream narrow word1", o_data[2][31:16], 16'h2000 + i[15:0]);
      chk("stream narrow word0", o_data[2][15:0], 16'h1000 + i[15:0]);
    end
    in_valid = 1'b0;
    step();
    chk("stream drained", o_valid[0], 1'b0);

    // Stall with skid capture.
    set_in(1'b1, 32'hA, 32'h0, 14'h0011);
    step();
    chk("stall A out", o_data[0][31:0], 32'hA);
    set_in(1'b1, 32'hB, 32'h0, 14'h0022);
    out_ready = 1'b0;
    #1;
    chk("noskid in_ready comb", o_ready[1], 1'b0);
    step();
    chk("skid full", o_cnt[0], 2'd2);
    set_in(1'b1, 32'hC, 32'h0, 14'h0033);
    repeat (4) begin
      step();
      chk("stall hold data", o_data[0][31:0], 32'hA);
      chk("stall hold ctrl", o_ctrl[0], 14'h0011);
      chk("stall count", o_cnt[0], 2'd2);
      chk("stall in_ready", o_ready[0], 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("drain B", o_data[0][31:0], 32'hB);
    chk("noskid swap C", o_data[1][31:0], 32'hC);
    chk("noskid count", o_cnt[1], 2'd1);
    step();
    chk("drain C", o_data[0][31:0], 32'hC);
    in_valid = 1'b0;
    step();
    chk("drain empty", o_cnt[0], 2'd0);

    // Flush while full with a simultaneous accept.
    set_in(1'b1, 32'hE, 32'h0, 14'h0204);
    step();
    out_ready = 1'b0;
    set_in(1'b1, 32'hF, 32'h0, 14'h0204);
    step();
    chk("pre-flush count", o_cnt[0], 2'd2);
    chk("pre-flush ctrl", o_ctrl[0], 14'h0204);
    flush = 1'b1;
    set_in(1'b1, 32'hD, 32'h0, 14'h3FFF);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", o_valid[0], 1'b0);
    chk("flush out_ctrl", o_ctrl[0], 14'h0);
    chk("flush count", o_cnt[0], 2'd0);
    chk("flush in_ready", o_ready[0], 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("flushed D absent", o_valid[0], 1'b0);
    end

    // Randomized traffic, rare flush and reset.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 14'($urandom));
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
